capture_buffer: RTL and testbench

CAPTURE_BUFFER -- requirements
Module: capture_buffer

---
 rtl/capture_buffer.sv | 134 +++++++++++++
 tb/tb_capture_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
`default_nettype none
// ============================================================================
// capture_buffer
//   ADC sample capture FIFO with a small control FSM (CLEAR/IDLE/FILL/DRAIN).
//   Samples are stored while write_cmd is high and popped one per read_cmd
//   pulse. Sticky overflow/underflow flags are cleared only by CLEAR or reset.
// Revision: 1.0
// ============================================================================
module capture_buffer #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_cmd,
  input  logic              read_cmd,
  input  logic              reset_cmd,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic [1:0]        state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            cur_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic clearing;
  logic rd_accept;
  logic wr_accept;

  // A clear request (or sitting in CLEAR) blocks every read and write.
  assign clearing  = reset_cmd || (cur_state == CLEAR);
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign rd_accept = read_cmd && !empty && !clearing;
  // A write into a full buffer is allowed when a read frees a slot the same cycle.
  assign wr_accept = write_cmd && adc_valid && !clearing && (!full || rd_accept);
  assign state     = cur_state;

  // Sample memory write port; kept reset-free so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr] <= adc_data;
    end
  end

  // Pointers, occupancy, read data path and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clearing) begin
      // Stored samples are discarded; rd_data keeps its last value.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (write_cmd && adc_valid && !wr_accept) begin
        overflow <= 1'b1;
      end
      if (read_cmd && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Control FSM; transitions are judged on the registered occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state <= CLEAR;
    end else if (reset_cmd) begin
      cur_state <= CLEAR;
    end else begin
      case (cur_state)
        CLEAR: cur_state <= IDLE;
        IDLE:  cur_state <= write_cmd ? FILL : IDLE;
        FILL: begin
          if (!write_cmd) begin
            cur_state <= empty ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (write_cmd) begin
            cur_state <= FILL;
          end else if (empty) begin
            cur_state <= IDLE;
          end
        end
        default: cur_state <= CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_buffer.sv
`default_nettype none
// ============================================================================
// tb_capture_buffer
//   Directed capture/drain scenarios followed by randomized traffic, all
//   compared cycle by cycle against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_capture_buffer;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              write_cmd = 1'b0;
  logic              read_cmd = 1'b0;
  logic              reset_cmd = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  logic [1:0]        state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: stored samples as a queue plus plain flags.
  logic [DATA_W-1:0] m_q[$];
  int                m_state;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid;
  logic              m_ov;
  logic              m_un;

  capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .write_cmd (write_cmd),
    .read_cmd  (read_cmd),
    .reset_cmd (reset_cmd),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .state     (state)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state  = 0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ov     = 1'b0;
    m_un     = 1'b0;
  endtask

  // One clock of the specified behaviour, from the inputs present at the edge.
  task automatic model_step(input logic w, input logic r, input logic rc,
                            input logic v, input logic [DATA_W-1:0] d);
    int  n0;
    bit  racc;
    bit  wacc;
    n0 = m_q.size();
    if (rc || m_state == 0) begin
      m_q.delete();
      m_ov     = 1'b0;
      m_un     = 1'b0;
      m_rvalid = 1'b0;
    end else begin
      racc = r && (n0 > 0);
      wacc = w && v && ((n0 < DEPTH) || racc);
      if (r && n0 == 0) m_un = 1'b1;
      if (w && v && !wacc) m_ov = 1'b1;
      m_rvalid = racc;
      if (racc) m_rdata = m_q.pop_front();
      if (wacc) m_q.push_back(d);
    end
    if (rc) m_state = 0;
    else begin
      case (m_state)
        0: m_state = 1;
        1: m_state = w ? 2 : 1;
        2: if (!w) m_state = (n0 > 0) ? 3 : 1;
        default: if (w) m_state = 2; else if (n0 == 0) m_state = 1;
      endcase
    end
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_state));
    check("count", 32'(count), 32'(m_q.size()));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
    check("rd_valid", 32'(rd_valid), 32'(m_rvalid));
    check("rd_data", 32'(rd_data), 32'(m_rdata));
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare just after the edge.
  task automatic cycle(input logic w, input logic r, input logic rc,
                       input logic v, input logic [DATA_W-1:0] d);
    write_cmd = w;
    read_cmd  = r;
    reset_cmd = rc;
    adc_valid = v;
    adc_data  = d;
    @(posedge clock);
    model_step(w, r, rc, v, d);
    #1;
    check_all();
  endtask

  initial begin
    logic w_lvl;
    int   rd_pct;

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_all();

    // Release reset: CLEAR then IDLE.
    reset = 1'b1;
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);

    // Capture 0..999, then stop the window.
    for (int i = 0; i < 1000; i++) cycle(1, 0, 0, 1, DATA_W'(i));
    cycle(0, 0, 0, 0, '0);
    check("state_drain", 32'(state), 32'd3);

    // Drain all of them with spaced single-cycle read pulses.
    for (int i = 0; i < 1000; i++) begin
      cycle(0, 1, 0, 0, '0);
      repeat ($urandom_range(0, 3)) cycle(0, 0, 0, 0, '0);
    end
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
    check("state_idle_after_drain", 32'(state), 32'd1);

    // Overfill across the pointer wrap: 1030 samples.
    for (int i = 0; i < 1030; i++) cycle(1, 0, 0, 1, DATA_W'($urandom));
    check("full_after_1030", 32'(full), 32'd1);
    cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);

    // Clear, refill exactly, then concurrent read/write while full.
    cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 1, DATA_W'($urandom));
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, DATA_W'($urandom));
    check("ovf_clean_at_full_rw", 32'(overflow), 32'd0);
    cycle(0, 0, 0, 0, '0);

    // Bring occupancy to 500, then a one-cycle clear request.
    for (int i = 0; i < DEPTH - 500; i++) cycle(0, 1, 0, 0, '0);
    check("count_500", 32'(count), 32'd500);
    cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
    check("underflow_after_clear", 32'(underflow), 32'd1);

    // Randomized traffic with occasional clears.
    w_lvl  = 1'b0;
    rd_pct = 30;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 39) == 0) w_lvl = ~w_lvl;
      if (i % 700 == 0) rd_pct = $urandom_range(2, 60);
      cycle(w_lvl, ($urandom_range(0, 99) < rd_pct), ($urandom_range(0, 599) == 0),
            $urandom_range(0, 1) == 1, DATA_W'($urandom));
    end

    // Asynchronous reset between edges.
    #3;
    reset = 1'b0;
    #2;
    model_reset();
    check("async_state", 32'(state), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_rd_data", 32'(rd_data), 32'd0);
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1, i[0], 0, 1, DATA_W'(i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
